register_arbiter: RTL and testbench

REGISTER_ARBITER -- requirements
Module: register_arbiter

---
 rtl/register_arbiter.sv | 116 +++++++++++
 tb/tb_register_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/register_arbiter.sv
// Two-requester arbiter driving a shared register's LD/INC/NOP command port.
// Latency: command, ack and busy appear one edge after req is sampled in IDLE; one op per 2 cycles.
// Backpressure: requesters hold req/op_ld/data until ack; round-robin ties with REGISTER_ARBITER_ROUND_ROBIN_EN.
module register_arbiter #(
    parameter int WIDTH = 8,
    parameter int CNT_WIDTH = 16,
    localparam int REG_CTRL_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      sync_reset_n,
    input  logic [1:0]                req,
    input  logic [1:0]                op_ld,
    input  logic [WIDTH-1:0]          data0,
    input  logic [WIDTH-1:0]          data1,
    output logic [1:0]                ack,
    output logic [REG_CTRL_WIDTH-1:0] reg_ctrl,
    output logic [WIDTH-1:0]          reg_data,
    output logic                      busy,
    output logic [CNT_WIDTH-1:0]      ops_done
);

    // Command encodings shared with the register block (register.vh).
    localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_NOP = 2'b00;
    localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_LD  = 2'b01;
    localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_INC = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                      state, state_nxt;
    logic [REG_CTRL_WIDTH-1:0]   reg_ctrl_nxt;
    logic [WIDTH-1:0]            reg_data_nxt;
    logic [1:0]                  ack_nxt;
    logic                        busy_nxt;
    logic [CNT_WIDTH-1:0]        ops_done_nxt;
    logic                        win;

`ifdef REGISTER_ARBITER_ROUND_ROBIN_EN
    logic rr_ptr, rr_ptr_nxt;

    // rr_ptr remembers the last winner; on a tie the other requester goes.
    always_comb begin
        win = 1'b0;
        if (req == 2'b11) begin
            win = ~rr_ptr;
        end else begin
            win = req[1];
        end
    end
`else
    always_comb begin
        win = ~req[0];
    end
`endif

    always_comb begin
        state_nxt    = state;
        reg_ctrl_nxt = REG_CTRL_NOP;
        reg_data_nxt = reg_data;
        ack_nxt      = 2'b00;
        busy_nxt     = 1'b0;
        ops_done_nxt = ops_done;
`ifdef REGISTER_ARBITER_ROUND_ROBIN_EN
        rr_ptr_nxt   = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt    = ISSUE;
                    reg_ctrl_nxt = op_ld[win] ? REG_CTRL_LD : REG_CTRL_INC;
                    reg_data_nxt = win ? data1 : data0;
                    ack_nxt      = win ? 2'b10 : 2'b01;
                    busy_nxt     = 1'b1;
`ifdef REGISTER_ARBITER_ROUND_ROBIN_EN
                    rr_ptr_nxt   = win;
`endif
                end
            end
            ISSUE: begin
                // Counted on the edge that completes the issue cycle, so a reset there drops it.
                state_nxt    = IDLE;
                ops_done_nxt = ops_done + CNT_WIDTH'(1);
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            state    <= IDLE;
            reg_ctrl <= REG_CTRL_NOP;
            reg_data <= '0;
            ack      <= 2'b00;
            busy     <= 1'b0;
            ops_done <= '0;
`ifdef REGISTER_ARBITER_ROUND_ROBIN_EN
            rr_ptr   <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            reg_ctrl <= reg_ctrl_nxt;
            reg_data <= reg_data_nxt;
            ack      <= ack_nxt;
            busy     <= busy_nxt;
            ops_done <= ops_done_nxt;
`ifdef REGISTER_ARBITER_ROUND_ROBIN_EN
            rr_ptr   <= rr_ptr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_register_arbiter.sv
// Directed bench for register_arbiter: reset, load, tie handling, mid-op reset and counter wrap.
module tb_register_arbiter;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] LD  = 2'b01;
    localparam logic [1:0] INC = 2'b10;

    logic        clk = 1'b0;
    logic        sync_reset_n;
    logic [1:0]  req, op_ld;
    logic [7:0]  data0, data1;
    logic [1:0]  ack, reg_ctrl;
    logic [7:0]  reg_data;
    logic        busy;
    logic [15:0] ops_done;
    logic [1:0]  ack_w, reg_ctrl_w;
    logic [7:0]  reg_data_w;
    logic        busy_w;
    logic [3:0]  ops_done_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    register_arbiter #(.WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .sync_reset_n(sync_reset_n), .req(req), .op_ld(op_ld),
        .data0(data0), .data1(data1), .ack(ack), .reg_ctrl(reg_ctrl),
        .reg_data(reg_data), .busy(busy), .ops_done(ops_done)
    );

    register_arbiter #(.WIDTH(8), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .sync_reset_n(sync_reset_n), .req(req), .op_ld(op_ld),
        .data0(data0), .data1(data1), .ack(ack_w), .reg_ctrl(reg_ctrl_w),
        .reg_data(reg_data_w), .busy(busy_w), .ops_done(ops_done_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] e_ctrl, input logic [7:0] e_data,
                             input logic [1:0] e_ack, input logic e_busy, input logic [15:0] e_ops);
        check({tag, ".reg_ctrl"}, 32'(reg_ctrl), 32'(e_ctrl));
        check({tag, ".reg_data"}, 32'(reg_data), 32'(e_data));
        check({tag, ".ack"},      32'(ack),      32'(e_ack));
        check({tag, ".busy"},     32'(busy),     32'(e_busy));
        check({tag, ".ops_done"}, 32'(ops_done), 32'(e_ops));
    endtask

    logic [1:0] exp_ack;
    logic [7:0] exp_data;

    initial begin
        sync_reset_n = 1'b0;
        req   = 2'b11;
        op_ld = 2'b00;
        data0 = 8'h00;
        data1 = 8'h00;

        // Reset held for two edges with both requesting.
        tick();
        check_out("rst1", NOP, 8'h00, 2'b00, 1'b0, 16'd0);
        tick();
        check_out("rst2", NOP, 8'h00, 2'b00, 1'b0, 16'd0);

        // Single load from requester 0 on the first edge after release.
        sync_reset_n = 1'b1;
        req   = 2'b01;
        op_ld = 2'b01;
        data0 = 8'h5A;
        tick();
        check_out("ld_issue", LD, 8'h5A, 2'b01, 1'b1, 16'd0);
        req = 2'b00;
        tick();
        check_out("ld_done", NOP, 8'h5A, 2'b00, 1'b0, 16'd1);
        tick();
        check_out("idle_hold", NOP, 8'h5A, 2'b00, 1'b0, 16'd1);

        // Reset without a clock edge changes nothing.
        #2 sync_reset_n = 1'b0;
        #2 check("async_rst_no_effect", 32'(ops_done), 32'd1);
        sync_reset_n = 1'b1;

        // Requester 1 alone, then a req change during ISSUE is ignored.
        req   = 2'b10;
        op_ld = 2'b10;
        data1 = 8'hC3;
        tick();
        check_out("r1_issue", LD, 8'hC3, 2'b10, 1'b1, 16'd1);
        req   = 2'b01;
        op_ld = 2'b00;
        data0 = 8'h11;
        tick();
        check_out("issue_ignores_req", NOP, 8'hC3, 2'b00, 1'b0, 16'd2);
        tick();
        check_out("r0_inc", INC, 8'h11, 2'b01, 1'b1, 16'd2);
        req = 2'b00;
        tick();
        check_out("r0_inc_done", NOP, 8'h11, 2'b00, 1'b0, 16'd3);

        // Fresh reset so the tie starts from ops_done = 0 and pointer = 0.
        sync_reset_n = 1'b0;
        tick();
        check_out("rst3", NOP, 8'h00, 2'b00, 1'b0, 16'd0);
        sync_reset_n = 1'b1;
        req   = 2'b11;
        op_ld = 2'b00;
        data0 = 8'h44;
        data1 = 8'h33;
        for (int k = 0; k < 4; k++) begin
`ifdef REGISTER_ARBITER_ROUND_ROBIN_EN
            exp_ack  = (k % 2 == 0) ? 2'b10 : 2'b01;
            exp_data = (k % 2 == 0) ? 8'h33 : 8'h44;
`else
            exp_ack  = 2'b01;
            exp_data = 8'h44;
`endif
            tick();
            check_out($sformatf("tie_issue%0d", k), INC, exp_data, exp_ack, 1'b1, 16'(2 * k - 2 * k + k));
            tick();
            check_out($sformatf("tie_gap%0d", k), NOP, exp_data, 2'b00, 1'b0, 16'(k + 1));
        end
        check("tie_ops_done", 32'(ops_done), 32'd4);

        // Reset on the edge that would end the issue cycle aborts it.
        req   = 2'b01;
        op_ld = 2'b01;
        data0 = 8'hA5;
        tick();
        check_out("mid_issue", LD, 8'hA5, 2'b01, 1'b1, 16'd4);
        sync_reset_n = 1'b0;
        req = 2'b00;
        tick();
        check_out("mid_rst", NOP, 8'h00, 2'b00, 1'b0, 16'd0);
        check("mid_rst_w_ops", 32'(ops_done_w), 32'd0);
        sync_reset_n = 1'b1;

        // Sixteen increments wrap the 4-bit counter back to zero.
        req   = 2'b01;
        op_ld = 2'b00;
        for (int n = 1; n <= 16; n++) begin
            tick();
            tick();
            if (n == 15) check("wrap_w_15", 32'(ops_done_w), 32'd15);
        end
        check("wrap_w_0", 32'(ops_done_w), 32'd0);
        check("wrap_16bit", 32'(ops_done), 32'd16);
        check("wrap_w_ack_idle", 32'(ack_w), 32'd0);
        req = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
